// File: rtl/cache_miss_ctrl_pkg.sv
// Shared constants, address-field slices, FSM encoding and latched-request payload
// for the single-set cache miss controller.
package cache_miss_ctrl_pkg;

  localparam int unsigned WAYS       = 8;
  localparam int unsigned WAY_W      = $clog2(WAYS);
  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
  localparam int unsigned TAG_W      = 24;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LINE_W     = LINE_BYTES * BYTE_W;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned TAG_LSB    = ADDR_W - TAG_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL_REQ,
    ST_FILL,
    ST_UPDATE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic              write;
    logic [TAG_W-1:0]  tag;
    logic [OFF_W-1:0]  off;
    logic [BYTE_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/cache_miss_ctrl_victim_rr.sv
// Round-robin victim way pointer: advances once per completed line fill,
// presented as a one-hot way select.
module cache_victim_rr
  import cache_miss_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance_i,
  output logic [WAYS-1:0] way_oh_o
);

  logic [WAY_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = ptr_q + WAY_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign way_oh_o = WAYS'(1) << ptr_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Sequences byte load/store requests against one 8-way cache set: lookup, byte-serial
// line fill on miss, tag/valid update, then replayed lookup.
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [BYTE_W-1:0]     req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [BYTE_W-1:0]     resp_rdata,
  output logic                  stall,
  input  logic [WAYS-1:0]       hit_way,
  input  logic [LINE_W-1:0]     line_data,
  output logic                  hit_o,
  output logic                  set_out,
  output logic                  mem_write,
  output logic [WAYS-1:0]       dec_way,
  output logic [LINE_BYTES-1:0] dec_byte,
  output logic [OFF_W-1:0]      offset,
  output logic [BYTE_W-1:0]     byte_data,
  output logic [TAG_W-1:0]      in_tag,
  output logic                  inp_viv,
  output logic [BYTE_W-1:0]     fill_data,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [BYTE_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] rdata_q, rdata_d;
  logic [WAYS-1:0]   victim_oh;
  logic              lookup_hit;
  logic              unused_addr_bits;

  assign lookup_hit       = |hit_way;
  assign unused_addr_bits = ^req_addr[TAG_LSB-1:OFF_W];

  cache_victim_rr u_victim (
    .clk       (clk),
    .rst_n     (reset),
    .advance_i (state_q == ST_UPDATE),
    .way_oh_o  (victim_oh)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state plus request latch, fill beat counter and load-data capture.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.write = req_write;
          req_d.tag   = req_addr[ADDR_W-1:TAG_LSB];
          req_d.off   = req_addr[OFF_W-1:0];
          req_d.wdata = req_wdata;
          state_d     = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (lookup_hit) begin
          if (!req_q.write) rdata_d = line_data[{req_q.off, 3'b000} +: BYTE_W];
          state_d = ST_RESP;
        end else begin
          state_d = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: if (mem_ack) state_d = ST_FILL;
      ST_FILL: begin
        if (mem_rvalid) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(LINE_BYTES - 1)) state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_LOOKUP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Cache-set and memory-port strobes decoded from state.
  always_comb begin
    req_ready  = 1'b0;
    stall      = 1'b1;
    resp_valid = 1'b0;
    hit_o      = 1'b0;
    set_out    = 1'b0;
    mem_write  = 1'b0;
    dec_way    = '0;
    dec_byte   = '0;
    in_tag     = '0;
    inp_viv    = 1'b0;
    fill_data  = '0;
    mem_req    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        stall     = 1'b0;
      end
      ST_LOOKUP: begin
        if (lookup_hit) begin
          dec_way   = hit_way;
          hit_o     = 1'b1;
          mem_write = req_q.write;
        end else begin
          dec_way = victim_oh;
        end
      end
      ST_FILL_REQ: mem_req = 1'b1;
      ST_FILL: begin
        dec_way = victim_oh;
        if (mem_rvalid) begin
          set_out   = 1'b1;
          dec_byte  = LINE_BYTES'(1) << cnt_q;
          fill_data = mem_rdata;
          in_tag    = req_q.tag;
        end
      end
      ST_UPDATE: begin
        set_out = 1'b1;
        inp_viv = 1'b1;
        in_tag  = req_q.tag;
        dec_way = victim_oh;
      end
      ST_RESP: begin
        stall      = 1'b0;
        resp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign offset     = req_q.off;
  assign byte_data  = req_q.wdata;
  assign mem_addr   = {req_q.tag, {TAG_LSB{1'b0}}};
  assign resp_rdata = rdata_q;

endmodule
